// File: rtl/mips_io_port_responder.sv
// Memory-mapped I/O port for a MIPS MEM stage: an output latch, a synchronized input
// port, and a FIFO of input-change samples with sticky change/overflow flags.
module mips_io_port_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h1001_0040,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic [31:0] PortOut,
  output logic        IrqPending
);

  localparam int         PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [4:0]    count;
  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    prev;
  logic          chg;
  logic          ovf;

  logic [1:0]  offset;
  logic        empty;
  logic        full;
  logic        out_we;
  logic [1:0]  w1c;
  logic        pop_req;
  logic        push;
  logic        do_pop;
  logic        do_push;
  logic        ovf_event;
  logic [31:0] status;
  logic        byte_lane_unused;

  assign byte_lane_unused = ^Address[1:0];

  // Decode and FIFO control; a push into a full FIFO only succeeds if a pop frees a slot.
  always_comb begin
    Hit       = (Address[31:4] == BASE_ADDRESS[31:4]);
    offset    = Address[3:2];
    empty     = (count == 5'd0);
    full      = (count == DEPTH);
    out_we    = MemWrite && Hit && (offset == 2'd0);
    w1c       = (MemWrite && Hit && (offset == 2'd2)) ? WriteData[1:0] : 2'b00;
    pop_req   = MemRead && Hit && (offset == 2'd3);
    push      = (sync2 != prev);
    do_pop    = pop_req && !empty;
    do_push   = push && (!full || do_pop);
    ovf_event = push && full && !do_pop;
    status    = {23'b0, count, full, empty, ovf, chg};
  end

  always_comb begin
    ReadData = 32'h0;
    if (MemRead && Hit) begin
      case (offset)
        2'd0:    ReadData = PortOut;
        2'd1:    ReadData = {24'b0, sync2};
        2'd2:    ReadData = status;
        default: ReadData = empty ? 32'h0 : {24'b0, fifo_mem[rd_ptr]};
      endcase
    end
  end

  assign IrqPending = chg || !empty;

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      fifo_mem[wr_ptr] <= sync2;
    end
  end

  // Flag updates let a new event win over a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      PortOut <= 32'h0;
      sync1   <= 8'h0;
      sync2   <= 8'h0;
      prev    <= 8'h0;
      chg     <= 1'b0;
      ovf     <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= 5'd0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      prev  <= sync2;
      if (out_we) begin
        PortOut <= WriteData;
      end
      chg <= (chg && !w1c[0]) || push;
      ovf <= (ovf && !w1c[1]) || ovf_event;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_io_port_responder.sv
// Scoreboard bench for mips_io_port_responder: stimulus queues expected values,
// a monitor compares them at the falling edge of each observed cycle.
module tb_mips_io_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0040;
  localparam logic [31:0] OUTR = BASE;
  localparam logic [31:0] INR  = BASE + 32'h4;
  localparam logic [31:0] STR  = BASE + 32'h8;
  localparam logic [31:0] POPR = BASE + 32'hC;
  localparam int SEL_RD  = 0;
  localparam int SEL_PO  = 1;
  localparam int SEL_IRQ = 2;
  localparam int SEL_HIT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [7:0]  PortIn = 8'h0;
  logic [31:0] ReadData;
  logic        Hit;
  logic [31:0] PortOut;
  logic        IrqPending;

  logic        obs = 1'b0;
  logic [31:0] exp_q [$];
  int          sel_q [$];
  string       name_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  logic [31:0] mon_exp;
  logic [31:0] mon_act;
  int          mon_sel;
  string       mon_name;

  mips_io_port_responder #(.BASE_ADDRESS(BASE), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .PortIn(PortIn),
    .ReadData(ReadData), .Hit(Hit), .PortOut(PortOut), .IrqPending(IrqPending)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expectation per observed cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (obs) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_observation: no expected value queued at %0t", $time);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_sel  = sel_q.pop_front();
          mon_name = name_q.pop_front();
          case (mon_sel)
            SEL_RD:  mon_act = ReadData;
            SEL_PO:  mon_act = PortOut;
            SEL_IRQ: mon_act = {31'b0, IrqPending};
            default: mon_act = {31'b0, Hit};
          endcase
          if (mon_act !== mon_exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", mon_name, mon_act, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_val(input int sel, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    sel_q.push_back(sel);
    name_q.push_back(n);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Address   = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] e, input string n);
    MemRead = 1'b1;
    Address = a;
    obs     = 1'b1;
    expect_val(SEL_RD, e, n);
    tick();
    MemRead = 1'b0;
    obs     = 1'b0;
  endtask

  task automatic do_rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e,
                       input string n);
    MemWrite  = 1'b1;
    WriteData = d;
    do_read(a, e, n);
    MemWrite  = 1'b0;
  endtask

  task automatic probe(input int sel, input logic [31:0] a, input logic [31:0] e,
                       input string n);
    Address = a;
    obs     = 1'b1;
    expect_val(sel, e, n);
    tick();
    obs     = 1'b0;
  endtask

  task automatic set_in(input logic [7:0] v);
    PortIn = v;
    tick();
  endtask

  initial begin
    idle(2);
    reset = 1'b0;

    probe(SEL_PO, OUTR, 32'h0, "reset_portout");
    probe(SEL_IRQ, OUTR, 32'h0, "reset_irq");
    do_read(STR, 32'h4, "reset_status");
    do_read(INR, 32'h0, "reset_in_data");
    probe(SEL_HIT, POPR, 32'h1, "hit_top_offset");
    probe(SEL_HIT, BASE + 32'h10, 32'h0, "hit_above_window");
    probe(SEL_HIT, BASE - 32'h4, 32'h0, "hit_below_window");

    do_write(OUTR, 32'hDEAD_BEEF);
    probe(SEL_PO, OUTR, 32'hDEAD_BEEF, "store_portout");
    do_read(OUTR, 32'hDEAD_BEEF, "load_out_data");
    do_rw(OUTR, 32'h1234_5678, 32'hDEAD_BEEF, "rw_reads_pre_edge");
    do_read(OUTR, 32'h1234_5678, "rw_write_applied");
    do_write(INR, 32'hFFFF_FFFF);
    do_read(OUTR, 32'h1234_5678, "in_write_ignored");

    // Input change latency: IN_DATA after two edges, CHG/COUNT after three.
    PortIn = 8'h5A;
    do_read(INR, 32'h0, "in_data_edge0");
    do_read(INR, 32'h0, "in_data_edge1");
    do_read(INR, 32'h5A, "in_data_edge2");
    do_read(STR, 32'h11, "status_first_change");
    probe(SEL_IRQ, OUTR, 32'h1, "irq_on_change");
    do_write(STR, 32'h1);
    do_read(STR, 32'h10, "status_chg_cleared");
    probe(SEL_IRQ, OUTR, 32'h1, "irq_fifo_nonempty");
    do_read(POPR, 32'h5A, "pop_first_sample");
    do_read(STR, 32'h4, "status_drained");
    probe(SEL_IRQ, OUTR, 32'h0, "irq_idle");

    // Overflow: five changes into a four-deep FIFO.
    set_in(8'h11); set_in(8'h22); set_in(8'h33); set_in(8'h44); set_in(8'h55);
    idle(2);
    do_read(STR, 32'h4B, "status_overflow_full");
    do_read(POPR, 32'h11, "ovf_pop0");
    do_read(POPR, 32'h22, "ovf_pop1");
    do_read(POPR, 32'h33, "ovf_pop2");
    do_read(POPR, 32'h44, "ovf_pop3");
    do_read(STR, 32'h7, "status_after_drain");
    do_read(POPR, 32'h0, "pop_when_empty");
    do_read(STR, 32'h7, "status_empty_pop_no_change");
    do_write(STR, 32'h3);
    do_read(STR, 32'h4, "status_w1c_both");

    // Full FIFO with simultaneous push and pop.
    set_in(8'h01); set_in(8'h02); set_in(8'h03); set_in(8'h04); set_in(8'h05);
    idle(1);
    do_read(POPR, 32'h01, "full_pushpop_oldest");
    do_read(STR, 32'h49, "full_pushpop_status");
    do_read(POPR, 32'h02, "full_pop1");
    do_read(POPR, 32'h03, "full_pop2");
    do_read(POPR, 32'h04, "full_pop3");
    do_read(POPR, 32'h05, "full_pop_new_entry");
    do_read(STR, 32'h5, "full_drained_status");

    // Empty FIFO with simultaneous push and pop.
    set_in(8'h06);
    idle(1);
    do_read(POPR, 32'h0, "empty_pushpop_zero");
    do_read(STR, 32'h11, "empty_pushpop_status");
    do_read(POPR, 32'h06, "empty_pushpop_sample");

    // Change event coinciding with W1C of CHG and OVF.
    set_in(8'h07);
    idle(1);
    do_write(STR, 32'h3);
    do_read(STR, 32'h11, "w1c_set_wins");
    do_read(POPR, 32'h07, "w1c_sample");
    do_write(STR, 32'h1);
    do_read(STR, 32'h4, "status_clean");

    // Mid-operation reset with COUNT=3 and PortOut=0xFF.
    do_write(OUTR, 32'hFF);
    set_in(8'h10); set_in(8'h20); set_in(8'h30);
    idle(2);
    do_read(STR, 32'h31, "status_count3");
    do_write(POPR, 32'h0);
    do_read(STR, 32'h31, "pop_write_ignored");
    probe(SEL_PO, OUTR, 32'hFF, "portout_ff");
    reset  = 1'b1;
    PortIn = 8'h00;
    tick();
    do_read(STR, 32'h4, "status_during_reset");
    reset = 1'b0;
    probe(SEL_PO, OUTR, 32'h0, "reset_mid_portout");
    probe(SEL_IRQ, OUTR, 32'h0, "reset_mid_irq");
    do_read(STR, 32'h4, "reset_mid_status");
    do_read(POPR, 32'h0, "reset_mid_pop");
    do_read(OUTR, 32'h0, "reset_mid_out_data");
    do_write(BASE + 32'h20, 32'hAAAA_AAAA);
    probe(SEL_PO, OUTR, 32'h0, "nohit_store_ignored");
    probe(SEL_HIT, BASE + 32'h20, 32'h0, "nohit_address");

    // Nonzero input at reset release counts as a change.
    PortIn = 8'h81;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    idle(3);
    do_read(STR, 32'h11, "release_change_status");
    do_read(POPR, 32'h81, "release_change_sample");

    idle(2);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
